fifo_level: RTL and testbench

Parametrised synchronous FIFO that succeeds the plain UART FIFO. It adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags with clear. It sits between the UART RX/TX engines and the debug-unit/host side, where the consumer needs early back-pressure and error visibility rather than just full/empty.

---
 rtl/fifo_level_pkg.sv | 21 ++
 rtl/fifo_level_if.sv | 31 +++
 rtl/fifo_level_mem.sv | 22 ++
 rtl/fifo_level.sv | 105 ++++++++++
 tb/tb_fifo_level.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/fifo_level_pkg.sv
// Shared constants and the {wr,rd} operation encoding for the level-tracking FIFO.
package fifo_level_pkg;

  localparam int DEFAULT_FIFO_SIZE       = 16;
  localparam int DEFAULT_FIFO_WORD_WIDTH = 8;
  localparam int DEFAULT_FIFO_AF_LEVEL   = DEFAULT_FIFO_SIZE - 2;
  localparam int DEFAULT_FIFO_AE_LEVEL   = 1;

  localparam logic LOW   = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic CLEAR = 1'b0;

  // Encoding of the accepted {write, read} pair for one edge.
  typedef enum logic [1:0] {
    FIFO_STATE_IDLE           = 2'b00,
    FIFO_STATE_READ           = 2'b01,
    FIFO_STATE_WRITE          = 2'b10,
    FIFO_STATE_READ_AND_WRITE = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_level_if.sv
// Producer/consumer bundle of the FIFO: requests in, data and status out.
interface fifo_level_if #(
  parameter int FIFO_SIZE  = fifo_level_pkg::DEFAULT_FIFO_SIZE,
  parameter int WORD_WIDTH = fifo_level_pkg::DEFAULT_FIFO_WORD_WIDTH
);
  localparam int LW = $clog2(FIFO_SIZE) + 1;

  logic [WORD_WIDTH-1:0] w_data;
  logic                  wr;
  logic                  rd;
  logic                  flush;
  logic                  err_clr;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_data, wr, rd, flush, err_clr,
    input  r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  w_data, wr, rd, flush, err_clr,
    output r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_level_mem.sv
// Simple dual-port storage: synchronous write, asynchronous (show-ahead) read.
module fifo_mem #(
  parameter int FIFO_SIZE  = 16,
  parameter int WORD_WIDTH = 8,
  localparam int AW        = $clog2(FIFO_SIZE)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [WORD_WIDTH-1:0] rdata
);
  logic [WORD_WIDTH-1:0] mem [FIFO_SIZE];

  // Array is intentionally not reset; only pointers define valid contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy count, almost flags, flush and sticky errors.
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int FIFO_SIZE  = DEFAULT_FIFO_SIZE,
  parameter int WORD_WIDTH = DEFAULT_FIFO_WORD_WIDTH,
  parameter int AF_LEVEL   = FIFO_SIZE - 2,
  parameter int AE_LEVEL   = DEFAULT_FIFO_AE_LEVEL
) (
  input  logic         clk,
  input  logic         reset,
  fifo_level_if.slave  bus
);
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_L = LW'(FIFO_SIZE);
  localparam logic [LW-1:0] AF_L   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L   = LW'(AE_LEVEL);

  logic [AW-1:0] wptr_q, wptr_nxt, rptr_q, rptr_nxt;
  logic [LW-1:0] lvl_q, lvl_nxt;
  logic          full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic          ovf_nxt, unf_nxt;
  logic          wr_ok, rd_ok;
  fifo_op_e      op;

  // A full FIFO still takes a write when a read frees the slot in the same edge.
  assign wr_ok = bus.wr & (~full_q | bus.rd);
  assign rd_ok = bus.rd & ~empty_q;
  assign op    = fifo_op_e'({wr_ok, rd_ok});

  // Next pointers, level and sticky errors; flush overrides any request.
  always_comb begin
    wptr_nxt = wptr_q;
    rptr_nxt = rptr_q;
    lvl_nxt  = lvl_q;
    ovf_nxt  = bus.err_clr ? CLEAR : ovf_q;
    unf_nxt  = bus.err_clr ? CLEAR : unf_q;
    if (bus.flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
      lvl_nxt  = '0;
    end else begin
      if (bus.wr & full_q & ~bus.rd) ovf_nxt = HIGH;
      if (bus.rd & empty_q)          unf_nxt = HIGH;
      case (op)
        FIFO_STATE_WRITE: begin
          wptr_nxt = wptr_q + AW'(1);
          lvl_nxt  = lvl_q + LW'(1);
        end
        FIFO_STATE_READ: begin
          rptr_nxt = rptr_q + AW'(1);
          lvl_nxt  = lvl_q - LW'(1);
        end
        FIFO_STATE_READ_AND_WRITE: begin
          wptr_nxt = wptr_q + AW'(1);
          rptr_nxt = rptr_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // State register; flags are derived from the next level so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      lvl_q   <= '0;
      full_q  <= LOW;
      empty_q <= HIGH;
      af_q    <= LOW;
      ae_q    <= HIGH;
      ovf_q   <= LOW;
      unf_q   <= LOW;
    end else begin
      wptr_q  <= wptr_nxt;
      rptr_q  <= rptr_nxt;
      lvl_q   <= lvl_nxt;
      full_q  <= (lvl_nxt == FULL_L);
      empty_q <= (lvl_nxt == '0);
      af_q    <= (lvl_nxt >= AF_L);
      ae_q    <= (lvl_nxt <= AE_L);
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  fifo_mem #(.FIFO_SIZE(FIFO_SIZE), .WORD_WIDTH(WORD_WIDTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok & ~bus.flush),
    .waddr (wptr_q),
    .wdata (bus.w_data),
    .raddr (rptr_q),
    .rdata (bus.r_data)
  );

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = lvl_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level at FIFO_SIZE=8, WORD_WIDTH=8, AF=6, AE=1.
module tb_fifo_level;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  fifo_level_if #(.FIFO_SIZE(8), .WORD_WIDTH(8)) bus ();

  fifo_level #(.FIFO_SIZE(8), .WORD_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {full, empty, almost_full, almost_empty, overflow, underflow, level}
  wire [9:0] st = {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                   bus.overflow, bus.underflow, bus.level};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr = 0; bus.rd = 0; bus.flush = 0; bus.err_clr = 0;
  endtask

  task automatic test_reset();
    idle(); bus.w_data = 8'h00;
    reset = 0;
    step();
    checks++;
    if (st !== {6'b010100, 4'd0}) begin errors++; $display("FAIL reset_state got %b exp %b", st, {6'b010100, 4'd0}); end
    reset = 1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      bus.wr = 1; bus.w_data = 8'h11 + 8'(i);
      step();
      checks++;
      if (st !== {(i == 7), 1'b0, (i >= 5), (i == 0), 2'b00, 4'(i + 1)}) begin
        errors++; $display("FAIL fill_status[%0d] got %b exp %b", i, st, {(i == 7), 1'b0, (i >= 5), (i == 0), 2'b00, 4'(i + 1)});
      end
      checks++;
      if (bus.r_data !== 8'h11) begin errors++; $display("FAIL fill_head[%0d] got %h exp 11", i, bus.r_data); end
    end
    idle();
  endtask

  task automatic test_overflow();
    bus.wr = 1; bus.w_data = 8'hAA;
    step(); idle();
    checks++;
    if (st !== {6'b101010, 4'd8}) begin errors++; $display("FAIL ovf_status got %b exp %b", st, {6'b101010, 4'd8}); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.r_data !== 8'h11 + 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, bus.r_data, 8'h11 + 8'(i)); end
      bus.rd = 1; step();
    end
    idle();
    checks++;
    if (st !== {6'b010110, 4'd0}) begin errors++; $display("FAIL ovf_empty got %b exp %b", st, {6'b010110, 4'd0}); end
    bus.err_clr = 1; step(); idle();
    checks++;
    if (st !== {6'b010100, 4'd0}) begin errors++; $display("FAIL ovf_clear got %b exp %b", st, {6'b010100, 4'd0}); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [8] = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55, 8'h55, 8'h55};
    for (int i = 0; i < 8; i++) begin
      bus.wr = 1; bus.w_data = 8'h11 + 8'(i); step();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.r_data !== 8'h11 + 8'(i)) begin errors++; $display("FAIL frw_pop[%0d] got %h exp %h", i, bus.r_data, 8'h11 + 8'(i)); end
      bus.wr = 1; bus.rd = 1; bus.w_data = 8'h55; step();
      checks++;
      if (st !== {6'b101000, 4'd8}) begin errors++; $display("FAIL frw_status[%0d] got %b exp %b", i, st, {6'b101000, 4'd8}); end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.r_data !== exp_q[i]) begin errors++; $display("FAIL frw_drain[%0d] got %h exp %h", i, bus.r_data, exp_q[i]); end
      bus.rd = 1; step();
    end
    idle();
    checks++;
    if (st !== {6'b010100, 4'd0}) begin errors++; $display("FAIL frw_empty got %b exp %b", st, {6'b010100, 4'd0}); end
  endtask

  task automatic test_underflow();
    bus.wr = 1; bus.rd = 1; bus.w_data = 8'h77; step(); idle();
    checks++;
    if (st !== {6'b000101, 4'd1}) begin errors++; $display("FAIL unf_status got %b exp %b", st, {6'b000101, 4'd1}); end
    checks++;
    if (bus.r_data !== 8'h77) begin errors++; $display("FAIL unf_head got %h exp 77", bus.r_data); end
    bus.err_clr = 1; step(); idle();
    checks++;
    if (st !== {6'b000100, 4'd1}) begin errors++; $display("FAIL unf_clear got %b exp %b", st, {6'b000100, 4'd1}); end
    bus.rd = 1; step(); idle();
    checks++;
    if (st !== {6'b010100, 4'd0}) begin errors++; $display("FAIL unf_pop got %b exp %b", st, {6'b010100, 4'd0}); end
    bus.rd = 1; bus.err_clr = 1; step(); idle();
    checks++;
    if (st !== {6'b010101, 4'd0}) begin errors++; $display("FAIL unf_set_wins got %b exp %b", st, {6'b010101, 4'd0}); end
  endtask

  task automatic test_flush_wrap();
    for (int i = 0; i < 6; i++) begin bus.wr = 1; bus.w_data = 8'h21 + 8'(i); step(); end
    idle();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.r_data !== 8'h21 + 8'(i)) begin errors++; $display("FAIL wrap_pop[%0d] got %h exp %h", i, bus.r_data, 8'h21 + 8'(i)); end
      bus.rd = 1; step();
    end
    idle();
    for (int i = 0; i < 5; i++) begin bus.wr = 1; bus.w_data = 8'h31 + 8'(i); step(); end
    idle();
    checks++;
    if (st !== {6'b000001, 4'd5}) begin errors++; $display("FAIL wrap_level got %b exp %b", st, {6'b000001, 4'd5}); end
    checks++;
    if (bus.r_data !== 8'h31) begin errors++; $display("FAIL wrap_head got %h exp 31", bus.r_data); end
    bus.flush = 1; bus.wr = 1; bus.w_data = 8'h99; step(); idle();
    checks++;
    if (st !== {6'b010101, 4'd0}) begin errors++; $display("FAIL flush_status got %b exp %b", st, {6'b010101, 4'd0}); end
    bus.wr = 1; bus.w_data = 8'h42; step(); idle();
    checks++;
    if (bus.r_data !== 8'h42 || bus.level !== 4'd1) begin errors++; $display("FAIL flush_rewrite got %h/%0d exp 42/1", bus.r_data, bus.level); end
    bus.err_clr = 1; bus.rd = 1; step(); idle();
    checks++;
    if (st !== {6'b010100, 4'd0}) begin errors++; $display("FAIL flush_after got %b exp %b", st, {6'b010100, 4'd0}); end
  endtask

  task automatic test_async_reset();
    bus.rd = 1; step(); idle();
    for (int i = 0; i < 4; i++) begin bus.wr = 1; bus.w_data = 8'h01 + 8'(i); step(); end
    checks++;
    if (st !== {6'b000001, 4'd4}) begin errors++; $display("FAIL ares_pre got %b exp %b", st, {6'b000001, 4'd4}); end
    bus.w_data = 8'h05;
    #3 reset = 0;
    #1;
    checks++;
    if (st !== {6'b010100, 4'd0}) begin errors++; $display("FAIL ares_immediate got %b exp %b", st, {6'b010100, 4'd0}); end
    reset = 1;
    bus.wr = 1; bus.w_data = 8'h3C; step(); idle();
    checks++;
    if (bus.r_data !== 8'h3C || st !== {6'b000100, 4'd1}) begin
      errors++; $display("FAIL ares_first got %h/%b exp 3c/%b", bus.r_data, st, {6'b000100, 4'd1});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_flush_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
